mem_access_ctrl: RTL and testbench

Sequencer in front of the byte-wide `dataMemory`: accepts one byte, halfword or word load/store request from the pipeline and performs it as consecutive single-byte accesses. It handles big-endian byte ordering, alignment checking, and sign/zero extension of loads. It returns one response per request.

---
 rtl/mem_access_ctrl_if.sv | 55 +++++
 rtl/mem_access_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//
// Purpose: bundles the request/response handshake between the pipeline and
// the memory access sequencer, together with the byte-wide memory bus.
//
// Signal summary:
//   req_valid/req_ready     request handshake (pipeline -> controller)
//   req_write/size/signed   operation type, 00 byte, 01 half, 10 word
//   req_addr/req_wdata      byte address and right-justified store data
//   resp_valid/resp_ready   response handshake (controller -> pipeline)
//   resp_rdata/resp_err     extended load data and error flag
//   mem_addr/mem_wdata/
//   mem_we/mem_rdata        single-byte port of the data memory
//
// Modports:
//   slave  - the controller's view
//   master - the view of whatever drives requests and models the memory
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  // Controller side: consumes requests and memory read data, produces
  // responses and drives the memory bus.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we
  );

  // Requester / memory side: mirror image of the controller view.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose: sequencer in front of a byte-wide data memory. Takes one byte,
// halfword or word load/store from the pipeline and performs it as
// consecutive single-byte accesses, most significant byte at the lowest
// address (big-endian). Misaligned requests and the illegal size code are
// answered with an error response without touching memory. Loads are sign-
// or zero-extended to 32 bits. Exactly one response per accepted request.
//
// Ports:
//   clk    in   system clock, all state changes on the rising edge
//   rst_n  in   synchronous, active-low reset
//   bus    slave modport of mem_access_ctrl_if (request, response and
//               memory bus signals)
//
// Parameters:
//   ADDR_W      byte address width, must match the interface instance
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } CtrlState;

  CtrlState          r_state;
  CtrlState          w_nextState;

  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_idx;
  logic [31:0]       r_acc;
  logic              r_err;

  logic              w_reqErr;
  logic [1:0]        w_lastIdx;
  logic              w_lastByte;
  logic [1:0]        w_byteSel;
  logic [7:0]        w_storeByte;
  logic [31:0]       w_respData;

  // Alignment / size check on the incoming request. Halfwords must sit on
  // an even address, words on a multiple of four, and size 11 is never
  // legal. Because of this, an accepted access can never carry across the
  // top of the address space, so the address adder below needs no care.
  always_comb begin
    w_reqErr = 1'b0;
    case (bus.req_size)
      2'b00:   w_reqErr = 1'b0;
      2'b01:   w_reqErr = bus.req_addr[0];
      2'b10:   w_reqErr = (bus.req_addr[1:0] != 2'b00);
      default: w_reqErr = 1'b1;
    endcase
  end

  // Index of the last byte of the latched access (N-1). Size 11 can never
  // reach the access phase, so it shares the word encoding here.
  always_comb begin
    w_lastIdx = 2'd3;
    case (r_size)
      2'b00:   w_lastIdx = 2'd0;
      2'b01:   w_lastIdx = 2'd1;
      default: w_lastIdx = 2'd3;
    endcase
  end

  assign w_lastByte = (r_idx == w_lastIdx);

  // Big-endian store: the byte sent out at index k is byte (N-1-k) of the
  // right-justified store data, so the most significant byte goes first
  // and lands at the lowest address.
  assign w_byteSel = w_lastIdx - r_idx;

  always_comb begin
    w_storeByte = r_wdata[7:0];
    case (w_byteSel)
      2'd0:    w_storeByte = r_wdata[7:0];
      2'd1:    w_storeByte = r_wdata[15:8];
      2'd2:    w_storeByte = r_wdata[23:16];
      default: w_storeByte = r_wdata[31:24];
    endcase
  end

  // Response data: the accumulator holds the loaded bytes right-justified
  // with the first (lowest address) byte most significant, so only the low
  // N bytes are meaningful and the rest is filled from the sign bit or with
  // zeros. Stores and errors always answer with zero.
  always_comb begin
    w_respData = 32'd0;
    if (!r_write && !r_err) begin
      case (r_size)
        2'b00:   w_respData = {{24{r_signed & r_acc[7]}},  r_acc[7:0]};
        2'b01:   w_respData = {{16{r_signed & r_acc[15]}}, r_acc[15:0]};
        default: w_respData = r_acc;
      endcase
    end
  end

  // State register. Reset drops straight back to IDLE from anywhere, which
  // is also how an access in progress gets abandoned: no response follows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. Every output is a function of registered
  // state only, so nothing on the request side can reach the memory bus or
  // the response combinationally. The memory bus is parked at zero outside
  // the access phase.
  always_comb begin
    w_nextState    = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 8'd0;
    bus.mem_we     = 1'b0;

    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_nextState = w_reqErr ? RESP : ACCESS;
        end
      end

      ACCESS: begin
        bus.mem_addr = r_addr + ADDR_W'(r_idx);
        if (r_write) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = w_storeByte;
        end
        if (w_lastByte) begin
          w_nextState = RESP;
        end
      end

      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = w_respData;
        bus.resp_err   = r_err;
        if (bus.resp_ready) begin
          w_nextState = IDLE;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request latch and byte sequencing. The request fields are captured only
  // while idle, so anything presented during an access or while a response
  // waits is simply ignored. The accumulator is cleared on acceptance and
  // shifts one byte in per load cycle; the byte index stops at the last
  // byte rather than wrapping, so it is always zero-based on the next
  // acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_idx    <= 2'd0;
      r_acc    <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write  <= bus.req_write;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_err    <= w_reqErr;
            r_idx    <= 2'd0;
            r_acc    <= 32'd0;
          end
        end

        ACCESS: begin
          if (!r_write) begin
            r_acc <= {r_acc[23:0], bus.mem_rdata};
          end
          if (!w_lastByte) begin
            r_idx <= r_idx + 2'd1;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Purpose: self-checking bench for mem_access_ctrl. A byte-array memory
// sits on the controller's memory bus; a separate reference memory is
// updated at transaction level and used to predict load data, response
// latency, error responses and the number of memory writes. Directed cases
// cover big-endian layout, extension, errors, backpressure, reset during a
// store and back-to-back traffic, followed by randomized traffic.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;

  int total;
  int bad;
  int weCount;

  logic [7:0] memArr [0:4095];
  logic [7:0] refMem [0:4095];

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-wide data memory with combinational read; also counts every
  // write strobe it sees so the bench can check how many bytes were stored.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      memArr[bus.mem_addr[11:0]] <= bus.mem_wdata;
      weCount <= weCount + 1;
    end
  end

  assign bus.mem_rdata = memArr[bus.mem_addr[11:0]];

  // Safety net so the run always ends even if the handshake locks up.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit isBadReq(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'b11) || (sz == 2'b01 && (addr % 2) != 0) ||
           (sz == 2'b10 && (addr % 4) != 0);
  endfunction

  // Reference load: read n bytes big-endian, then extend.
  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input int n,
                                            input bit sg);
    logic [63:0] v;
    logic [11:0] a;
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      a = addr[11:0] + 12'(i);
      v = (v << 8) | 64'(refMem[a]);
    end
    if (sg && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v[31:0];
  endfunction

  // Reference store: most significant of the n bytes to the lowest address.
  task automatic modelStore(input logic [31:0] addr, input int n,
                            input logic [31:0] wd);
    logic [11:0] a;
    logic [31:0] sh;
    for (int i = 0; i < n; i++) begin
      a = addr[11:0] + 12'(i);
      sh = wd >> (8 * (n - 1 - i));
      refMem[a] = sh[7:0];
    end
  endtask

  // One full transaction, starting and ending at a falling edge with the
  // controller idle. The response is held for 'hold' cycles before being
  // taken; during that time a stray request is presented and must be
  // ignored.
  task automatic applyStimulus(input bit wr, input logic [1:0] sz, input bit sg,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int hold, output logic [31:0] rd,
                               output logic er);
    int          n;
    bit          expErr;
    logic [31:0] expData;
    int          cyc;
    int          weStart;
    logic [11:0] a;

    n       = sizeBytes(sz);
    expErr  = isBadReq(sz, addr);
    expData = (!wr && !expErr) ? modelLoad(addr, n, sg) : 32'd0;

    checkOutput("req_ready idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    weStart        = weCount;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    cyc = 1;
    while (bus.resp_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("resp latency", 64'(cyc), expErr ? 64'd1 : 64'(n + 1));
    checkOutput("resp_err", 64'(bus.resp_err), 64'(expErr));
    checkOutput("resp_rdata", 64'(bus.resp_rdata), 64'(expData));
    rd = bus.resp_rdata;
    er = bus.resp_err;

    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 2'b00;
      bus.req_addr  = addr ^ 32'h8;
      bus.req_wdata = $urandom;
      @(negedge clk);
      checkOutput("hold resp_valid", 64'(bus.resp_valid), 64'd1);
      checkOutput("hold resp_rdata", 64'(bus.resp_rdata), 64'(expData));
      checkOutput("hold resp_err", 64'(bus.resp_err), 64'(expErr));
      checkOutput("hold req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid = 1'b0;

    checkOutput("mem_we count", 64'(weCount - weStart),
                (wr && !expErr) ? 64'(n) : 64'd0);

    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checkOutput("resp_valid dropped", 64'(bus.resp_valid), 64'd0);
    checkOutput("req_ready after resp", 64'(bus.req_ready), 64'd1);

    if (wr && !expErr) begin
      modelStore(addr, n, wd);
      for (int i = 0; i < n; i++) begin
        a = addr[11:0] + 12'(i);
        checkOutput("stored byte", 64'(memArr[a]), 64'(refMem[a]));
      end
    end
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] rd;
    logic        er;
    int          weStart;
    logic [1:0]  rsz;
    logic [7:0]  old202;
    logic [7:0]  old203;

    total = 0;
    bad   = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      memArr[i] = b;
      refMem[i] = b;
    end

    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("reset resp_rdata", 64'(bus.resp_rdata), 64'd0);
    checkOutput("reset resp_err", 64'(bus.resp_err), 64'd0);
    checkOutput("reset mem_we", 64'(bus.mem_we), 64'd0);
    checkOutput("reset mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] word store / load");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, rd, er);
    checkOutput("mem 0x100", 64'(memArr[12'h100]), 64'hDE);
    checkOutput("mem 0x101", 64'(memArr[12'h101]), 64'hAD);
    checkOutput("mem 0x102", 64'(memArr[12'h102]), 64'hBE);
    checkOutput("mem 0x103", 64'(memArr[12'h103]), 64'hEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, rd, er);
    checkOutput("word load", 64'(rd), 64'hDEADBEEF);

    $display("[TB] extension");
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, rd, er);
    checkOutput("signed half", 64'(rd), 64'hFFFFBEEF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, rd, er);
    checkOutput("unsigned half", 64'(rd), 64'h0000BEEF);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 0, rd, er);
    checkOutput("signed byte", 64'(rd), 64'hFFFFFFAD);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, rd, er);
    checkOutput("unsigned byte", 64'(rd), 64'h000000EF);

    $display("[TB] errors");
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, rd, er);
    checkOutput("err word 0x101", 64'({er, rd}), 64'h1_0000_0000);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h103, 32'h1234, 0, rd, er);
    checkOutput("err half 0x103", 64'({er, rd}), 64'h1_0000_0000);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h100, 32'h55, 0, rd, er);
    checkOutput("err size 11", 64'({er, rd}), 64'h1_0000_0000);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, rd, er);
    checkOutput("held word load", 64'(rd), 64'hDEADBEEF);
    checkOutput("mem 0x108 untouched", 64'(memArr[12'h108]), 64'(refMem[12'h108]));

    $display("[TB] reset during store");
    old202  = refMem[12'h202];
    old203  = refMem[12'h203];
    weStart = weCount;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h200;
    bus.req_wdata  = 32'h11223344;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst req_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("rst resp_rdata", 64'(bus.resp_rdata), 64'd0);
    checkOutput("rst resp_err", 64'(bus.resp_err), 64'd0);
    checkOutput("rst mem_we", 64'(bus.mem_we), 64'd0);
    checkOutput("rst mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("rst mem_wdata", 64'(bus.mem_wdata), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no resp after reset", 64'(bus.resp_valid), 64'd0);
    end
    checkOutput("partial store count", 64'(weCount - weStart), 64'd2);
    checkOutput("rst mem 0x200", 64'(memArr[12'h200]), 64'h11);
    checkOutput("rst mem 0x201", 64'(memArr[12'h201]), 64'h22);
    checkOutput("rst mem 0x202", 64'(memArr[12'h202]), 64'(old202));
    checkOutput("rst mem 0x203", 64'(memArr[12'h203]), 64'(old203));
    refMem[12'h200] = 8'h11;
    refMem[12'h201] = 8'h22;

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h300, 32'h5A, 0, rd, er);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 0, rd, er);
    checkOutput("b2b load", 64'(rd), 64'h5A);

    $display("[TB] random traffic");
    for (int t = 0; t < 120; t++) begin
      rsz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) rsz = 2'b11;
      applyStimulus(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
                    32'h400 + 32'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 2), rd, er);
    end
    for (int i = 0; i < 16; i++) begin
      checkOutput("final mem", 64'(memArr[12'h400 + 12'(i)]),
                  64'(refMem[12'h400 + 12'(i)]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
